// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: single-transaction AXI4 INCR burst responder that turns each
// burst into a sequence of word accesses on a native valid/ready memory port.
// AW/AR handshakes and the write-data path are combinational by design so a
// same-cycle native memory sustains one write beat per cycle.
module axi4_mem_slave #(
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int AXI_ID_W   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   // write address
   input  logic [AXI_ID_W-1:0]     s_axi_awid,
   input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
   input  logic [AXI_LEN_W-1:0]    s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   // write data
   input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
   input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   // write response
   output logic [AXI_ID_W-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   // read address
   input  logic [AXI_ID_W-1:0]     s_axi_arid,
   input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
   input  logic [AXI_LEN_W-1:0]    s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   // read data
   output logic [AXI_ID_W-1:0]     s_axi_rid,
   output logic [AXI_DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   // native memory port
   output logic                    mem_valid,
   output logic [AXI_ADDR_W-1:0]   mem_addr,
   output logic [AXI_DATA_W-1:0]   mem_wdata,
   output logic [AXI_DATA_W/8-1:0] mem_wstrb,
   input  logic [AXI_DATA_W-1:0]   mem_rdata,
   input  logic                    mem_ready
);

   localparam int STRB_W = AXI_DATA_W / 8;
   localparam logic [AXI_ADDR_W-1:0] STRIDE     = AXI_ADDR_W'(STRB_W);
   localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~(STRIDE - AXI_ADDR_W'(1));

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4
   } state_t;

   state_t                  state_r, state_s;
   logic [AXI_ADDR_W-1:0]   addr_r;
   logic [AXI_LEN_W-1:0]    len_r;
   logic [AXI_LEN_W-1:0]    beat_r;
   logic [AXI_ID_W-1:0]     id_r;
   logic                    err_r;
   logic [AXI_DATA_W-1:0]   rdata_r;
   logic                    rlast_r;

   logic                    awready_s, arready_s, wready_s;
   logic                    bvalid_s, rvalid_s, mem_valid_s;
   logic [AXI_DATA_W-1:0]   mem_wdata_s;
   logic [STRB_W-1:0]       mem_wstrb_s;
   logic                    w_hs_s;
   logic                    last_beat_s;

   // size and burst type are fixed by the system (INCR, full width)
   logic unused_s;
   assign unused_s = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst};

   assign last_beat_s = (beat_r == len_r);

   // next-state logic and combinational handshake/native-port outputs
   always_comb begin
      state_s     = state_r;
      awready_s   = 1'b0;
      arready_s   = 1'b0;
      wready_s    = 1'b0;
      bvalid_s    = 1'b0;
      rvalid_s    = 1'b0;
      mem_valid_s = 1'b0;
      mem_wdata_s = '0;
      mem_wstrb_s = '0;
      w_hs_s      = 1'b0;
      case (state_r)
         IDLE: begin
            awready_s = s_axi_awvalid;
            arready_s = s_axi_arvalid & ~s_axi_awvalid;
            if (s_axi_awvalid) begin
               state_s = WR_DATA;
            end else if (s_axi_arvalid) begin
               state_s = RD_REQ;
            end else begin
               state_s = IDLE;
            end
         end
         WR_DATA: begin
            // an all-zero strobe beat is swallowed without touching memory
            mem_valid_s = s_axi_wvalid & (|s_axi_wstrb);
            mem_wdata_s = s_axi_wdata;
            mem_wstrb_s = s_axi_wstrb;
            wready_s    = (|s_axi_wstrb) ? mem_ready : 1'b1;
            w_hs_s      = s_axi_wvalid & wready_s;
            if (w_hs_s && last_beat_s) begin
               state_s = WR_RESP;
            end else begin
               state_s = WR_DATA;
            end
         end
         WR_RESP: begin
            bvalid_s = 1'b1;
            if (s_axi_bready) begin
               state_s = IDLE;
            end else begin
               state_s = WR_RESP;
            end
         end
         RD_REQ: begin
            mem_valid_s = 1'b1;
            if (mem_ready) begin
               state_s = RD_DATA;
            end else begin
               state_s = RD_REQ;
            end
         end
         RD_DATA: begin
            rvalid_s = 1'b1;
            if (s_axi_rready) begin
               state_s = rlast_r ? IDLE : RD_REQ;
            end else begin
               state_s = RD_DATA;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // state register plus burst address/counter, error flag and read data holding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         addr_r  <= '0;
         len_r   <= '0;
         beat_r  <= '0;
         id_r    <= '0;
         err_r   <= 1'b0;
         rdata_r <= '0;
         rlast_r <= 1'b0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (s_axi_awvalid) begin
                  id_r   <= s_axi_awid;
                  len_r  <= s_axi_awlen;
                  addr_r <= s_axi_awaddr & ALIGN_MASK;
                  beat_r <= '0;
                  err_r  <= 1'b0;
               end else if (s_axi_arvalid) begin
                  id_r   <= s_axi_arid;
                  len_r  <= s_axi_arlen;
                  addr_r <= s_axi_araddr & ALIGN_MASK;
                  beat_r <= '0;
               end
            end
            WR_DATA: begin
               if (w_hs_s) begin
                  addr_r <= addr_r + STRIDE;
                  beat_r <= beat_r + AXI_LEN_W'(1);
                  if (s_axi_wlast != last_beat_s) begin
                     err_r <= 1'b1;
                  end
               end
            end
            RD_REQ: begin
               if (mem_ready) begin
                  rdata_r <= mem_rdata;
                  rlast_r <= last_beat_s;
               end
            end
            RD_DATA: begin
               if (s_axi_rready) begin
                  addr_r <= addr_r + STRIDE;
                  beat_r <= beat_r + AXI_LEN_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign s_axi_awready = awready_s;
   assign s_axi_arready = arready_s;
   assign s_axi_wready  = wready_s;
   assign s_axi_bvalid  = bvalid_s;
   assign s_axi_bid     = id_r;
   assign s_axi_bresp   = (state_r == WR_RESP && err_r) ? 2'b10 : 2'b00;
   assign s_axi_rvalid  = rvalid_s;
   assign s_axi_rid     = id_r;
   assign s_axi_rdata   = rdata_r;
   assign s_axi_rresp   = 2'b00;
   assign s_axi_rlast   = rlast_r;
   assign mem_valid     = mem_valid_s;
   assign mem_addr      = addr_r;
   assign mem_wdata     = mem_wdata_s;
   assign mem_wstrb     = mem_wstrb_s;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: word memory model with programmable
// ready latency, AXI write/read burst tasks and hand-computed expectations.
module tb_axi4_mem_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [0:0]  s_axi_awid = '0;
   logic [31:0] s_axi_awaddr = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = 3'd2;
   logic [1:0]  s_axi_awburst = 2'b01;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [0:0]  s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [0:0]  s_axi_arid = '0;
   logic [31:0] s_axi_araddr = '0;
   logic [7:0]  s_axi_arlen = '0;
   logic [2:0]  s_axi_arsize = 3'd2;
   logic [1:0]  s_axi_arburst = 2'b01;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [0:0]  s_axi_rid;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_checks = 0;
   int n_errors = 0;

   axi4_mem_slave dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // memory model: 1024 words preloaded with 0xC0DE0000 + word index
   logic [31:0] mem [0:1023];
   logic [3:0]  wait_cnt = 4'd0;
   logic [3:0]  ready_delay = 4'd0;
   logic        init_done = 1'b0;

   assign mem_ready = mem_valid && (wait_cnt == ready_delay);
   assign mem_rdata = mem[mem_addr[11:2]];

   // preload once, then apply strobed writes and track the ready latency
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
         init_done <= 1'b1;
      end else if (mem_valid && mem_ready && mem_wstrb != 4'd0) begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (rst || !mem_valid || mem_ready) wait_cnt <= 4'd0;
      else wait_cnt <= wait_cnt + 4'd1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_ctrl"}, 32'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                                      s_axi_rvalid, s_axi_rlast, mem_valid}), 32'd0);
      check_val({tag, "_rdata"}, s_axi_rdata, 32'd0);
      check_val({tag, "_ids"}, 32'({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp}), 32'd0);
      check_val({tag, "_maddr"}, mem_addr, 32'd0);
      check_val({tag, "_mwdata"}, mem_wdata, 32'd0);
      check_val({tag, "_mwstrb"}, 32'(mem_wstrb), 32'd0);
   endtask

   task automatic axi_write(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] seed, input int last_at,
                            input logic [31:0] exp_base, input logic [1:0] exp_resp);
      int t;
      @(posedge clk); #1;
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
      @(negedge clk);
      check_val("awready", 32'(s_axi_awready), 32'd1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         s_axi_wvalid = 1'b1; s_axi_wdata = seed + 32'(i); s_axi_wstrb = 4'hF;
         s_axi_wlast = (i == last_at);
         t = 0;
         @(negedge clk);
         while (!s_axi_wready && t < 50) begin @(negedge clk); t++; end
         check_val("w_wait", 32'(t), 32'(ready_delay));
         check_val("w_mem_valid", 32'(mem_valid), 32'd1);
         check_val("w_mem_addr", mem_addr, exp_base + 32'(4 * i));
         check_val("w_mem_wdata", mem_wdata, seed + 32'(i));
         @(posedge clk); #1;
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wstrb = 4'h0; s_axi_bready = 1'b1;
      @(negedge clk);
      check_val("bvalid", 32'(s_axi_bvalid), 32'd1);
      check_val("bresp", 32'(s_axi_bresp), 32'(exp_resp));
      check_val("bid", 32'(s_axi_bid), 32'(id));
      check_val("b_mem_valid", 32'(mem_valid), 32'd0);
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
      @(negedge clk);
      check_val("bvalid_done", 32'(s_axi_bvalid), 32'd0);
   endtask

   task automatic read_beat(input logic [31:0] exp_data, input logic exp_last,
                            input logic [0:0] exp_id, input bit stall);
      int t = 0;
      @(negedge clk);
      while (!s_axi_rvalid && t < 50) begin @(negedge clk); t++; end
      check_val("r_wait", 32'(t), 32'd1 + 32'(ready_delay));
      check_val("rvalid", 32'(s_axi_rvalid), 32'd1);
      check_val("rdata", s_axi_rdata, exp_data);
      check_val("rlast", 32'(s_axi_rlast), 32'(exp_last));
      check_val("rresp", 32'(s_axi_rresp), 32'd0);
      check_val("rid", 32'(s_axi_rid), 32'(exp_id));
      if (stall) begin
         @(negedge clk);
         check_val("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
         check_val("r_hold_data", s_axi_rdata, exp_data);
         check_val("r_hold_memv", 32'(mem_valid), 32'd0);
      end
      s_axi_rready = 1'b1;
      @(posedge clk); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic axi_read(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] seed, input bit stall);
      @(posedge clk); #1;
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
      @(negedge clk);
      check_val("arready", 32'(s_axi_arready), 32'd1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++)
         read_beat(seed + 32'(i), (i == int'(len)), id, stall);
      @(negedge clk);
      check_val("r_done_rvalid", 32'(s_axi_rvalid), 32'd0);
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // 4-beat write then read back with rready toggling
      axi_write(1'b1, 32'h100, 8'd3, 32'hA5A5_0000, 3, 32'h100, 2'b00);
      axi_read(1'b1, 32'h100, 8'd3, 32'hA5A5_0000, 1'b1);

      // simultaneous AW and AR: write first, AR held off until IDLE
      @(posedge clk); #1;
      s_axi_awid = 1'b0; s_axi_awaddr = 32'h200; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
      s_axi_arid = 1'b0; s_axi_araddr = 32'h200; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
      @(negedge clk);
      check_val("both_awready", 32'(s_axi_awready), 32'd1);
      check_val("both_arready", 32'(s_axi_arready), 32'd0);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1;
      @(negedge clk);
      check_val("wr_arready", 32'(s_axi_arready), 32'd0);
      check_val("wr_wready", 32'(s_axi_wready), 32'd1);
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wstrb = 4'h0; s_axi_bready = 1'b1;
      @(negedge clk);
      check_val("resp_arready", 32'(s_axi_arready), 32'd0);
      check_val("resp_bvalid", 32'(s_axi_bvalid), 32'd1);
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
      @(negedge clk);
      check_val("idle_arready", 32'(s_axi_arready), 32'd1);
      s_axi_arvalid = 1'b0;
      axi_read(1'b0, 32'h200, 8'd0, 32'h1234_5678, 1'b0);

      // early wlast on beat 1 of a 3-beat burst: all beats land, SLVERR
      axi_write(1'b0, 32'h300, 8'd2, 32'h5A5A_0010, 1, 32'h300, 2'b10);
      axi_read(1'b0, 32'h300, 8'd2, 32'h5A5A_0010, 1'b0);

      // 256-beat read with two wait cycles per access (words 0x100..0x1FF)
      ready_delay = 4'd2;
      axi_read(1'b1, 32'h400, 8'd255, 32'hC0DE_0100, 1'b0);
      ready_delay = 4'd0;

      // reset pulse while beat 2 of a read is presented
      @(posedge clk); #1;
      s_axi_arid = 1'b1; s_axi_araddr = 32'h100; s_axi_arlen = 8'd3; s_axi_arvalid = 1'b1;
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      read_beat(32'hA5A5_0000, 1'b0, 1'b1, 1'b0);
      read_beat(32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
      t = 0;
      @(negedge clk);
      while (!s_axi_rvalid && t < 50) begin @(negedge clk); t++; end
      check_val("beat2_rdata", s_axi_rdata, 32'hA5A5_0002);
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      axi_read(1'b0, 32'h104, 8'd0, 32'hA5A5_0001, 1'b0);

      // unaligned start address is truncated to the word
      axi_write(1'b1, 32'h103, 8'd0, 32'hBEEF_0001, 0, 32'h100, 2'b00);
      axi_read(1'b1, 32'h100, 8'd0, 32'hBEEF_0001, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // overall watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
